// File: rtl/btn_conditioner.sv
// Three-channel button front end: 2-flop sync, debounce, press pulses and a
// pending-event queue with valid/ready. Optional auto-repeat: BTN_AUTOREPEAT_EN.
module btn_conditioner #(
  parameter int DEB_CYCLES    = 20000,
  parameter int REPEAT_DELAY  = 500000,
  parameter int REPEAT_PERIOD = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] btn_in,
  output logic [2:0] btn_level,
  output logic [2:0] btn_press,
  output logic       evt_valid,
  output logic [1:0] evt_code,
  input  logic       evt_ready,
  output logic       evt_drop
);

  // Handshake: an event transfers in any cycle where evt_valid && evt_ready;
  // evt_code stays stable while evt_valid && !evt_ready, and evt_ready is
  // ignored while evt_valid is low.

  localparam int CW = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] DEB_MAX = CW'(DEB_CYCLES - 1);

  logic [2:0]    sync1, sync2;
  logic [2:0]    level_q, level_d, press_q, pend;
  logic [CW-1:0] cnt [3];
  logic [1:0]    cur;
  logic          drop_q;
  logic [2:0]    rep_fire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
    end
  end

  // A single cycle of agreement with the current level restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == level_q[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DEB_MAX) begin
          level_q[i] <= sync2[i];
          cnt[i]     <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HW = $clog2(RMAX + 1);
  localparam logic [HW-1:0] DELAY_T  = HW'(REPEAT_DELAY);
  localparam logic [HW-1:0] PERIOD_T = HW'(REPEAT_PERIOD);

  logic [HW-1:0] hold_cnt [3];
  logic [2:0]    repeating;

  // hold_cnt equals cycles since the level rose; first target is the delay,
  // later targets are the period measured from the previous repeat.
  always_comb begin
    rep_fire = '0;
    for (int i = 0; i < 3; i++)
      rep_fire[i] = level_q[i] &&
                    (hold_cnt[i] == (repeating[i] ? PERIOD_T : DELAY_T));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      repeating <= '0;
      for (int i = 0; i < 3; i++) hold_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (!level_q[i]) begin
          hold_cnt[i]  <= '0;
          repeating[i] <= 1'b0;
        end else if (rep_fire[i]) begin
          hold_cnt[i]  <= HW'(1);
          repeating[i] <= 1'b1;
        end else begin
          hold_cnt[i] <= hold_cnt[i] + 1'b1;
        end
      end
    end
  end
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
  assign rep_fire = '0;
`endif

  logic       hs;
  logic [2:0] clr, pend_nxt;
  logic [1:0] cur_nxt;
  logic       drop_nxt;

  always_comb begin
    hs  = evt_valid && evt_ready;
    clr = '0;
    if (hs) begin
      case (cur)
        2'd1:    clr = 3'b001;
        2'd2:    clr = 3'b010;
        2'd3:    clr = 3'b100;
        default: clr = 3'b000;
      endcase
    end
    pend_nxt = (pend & ~clr) | press_q;
    drop_nxt = |(press_q & pend & ~clr);
    // The presented event is frozen while stalled so a later, higher-priority
    // press cannot preempt it.
    if (evt_valid && !evt_ready) cur_nxt = cur;
    else if (pend_nxt[0])        cur_nxt = 2'd1;
    else if (pend_nxt[1])        cur_nxt = 2'd2;
    else if (pend_nxt[2])        cur_nxt = 2'd3;
    else                         cur_nxt = 2'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_d <= '0;
      press_q <= '0;
      pend    <= '0;
      cur     <= '0;
      drop_q  <= 1'b0;
    end else begin
      level_d <= level_q;
      press_q <= (level_q & ~level_d) | rep_fire;
      pend    <= pend_nxt;
      cur     <= cur_nxt;
      drop_q  <= drop_nxt;
    end
  end

  assign btn_level = level_q;
  assign btn_press = press_q;
  assign evt_valid = |pend;
  assign evt_code  = cur;
  assign evt_drop  = drop_q;

endmodule
